vga_pixel_pipe: RTL and testbench

Pixel delivery stage directly downstream of the VGA interval generator. It buffers an incoming pixel stream from the framebuffer fetch logic in a small FIFO. It pops one pixel per active display cycle, using the generator's blank flags as the pop strobe. It emits colour, syncs and display-enable, all retimed by one register stage so they stay aligned. It also keeps the stream frame-locked using a start-of-frame marker, and recovers automatically from underruns and misaligned frames.

---
 rtl/vga_pixel_pipe.sv | 135 +++++++++++++
 tb/tb_vga_pixel_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_pipe.sv
// Pixel delivery stage behind the VGA interval generator: buffers the fetched pixel
// stream, pops one word per active cycle, and retimes colour/syncs/de by one register.
module vga_pixel_pipe #(
    parameter int              PW          = 24,
    parameter int              DEPTH       = 16,
    parameter logic [PW-1:0]   BLANK_COLOR = '0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     hsync_i,
    input  logic                     vsync_i,
    input  logic                     hblank_i,
    input  logic                     vblank_i,
    input  logic [PW-1:0]            s_tdata,
    input  logic                     s_tuser,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [PW-1:0]            rgb_o,
    output logic                     hsync_o,
    output logic                     vsync_o,
    output logic                     de_o,
    output logic                     underrun_o,
    output logic                     sof_err_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {RESYNC, ARMED, RUN} state_t;

    state_t          state, state_next;
    logic [PW:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   count;
    logic            first_flag;
    logic            active, full, empty, accept;
    logic            push, pop, underrun, sof_err, flush;
    logic [PW:0]     head;

    assign active   = ~hblank_i & ~vblank_i;
    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign s_tready = ~full;
    assign accept   = s_tvalid & s_tready;
    assign head     = mem[rd_ptr];
    assign level_o  = count;

    always_comb begin
        state_next = state;
        push       = 1'b0;
        pop        = 1'b0;
        underrun   = 1'b0;
        sof_err    = 1'b0;
        flush      = 1'b0;
        unique case (state)
            RESYNC: begin
                // Only a start-of-frame word may open a fresh FIFO fill.
                if (accept && s_tuser) begin
                    push       = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                push = accept;
                if (vblank_i) state_next = RUN;
            end
            RUN: begin
                push = accept;
                if (active) begin
                    if (empty) begin
                        underrun = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        sof_err = (head[PW] != first_flag);
                    end
                end
                // Any error drops the FIFO contents, including a word arriving now.
                if (underrun || sof_err) begin
                    flush      = 1'b1;
                    push       = 1'b0;
                    state_next = RESYNC;
                end
            end
            default: state_next = RESYNC;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= RESYNC;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            first_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)      count <= count + LW'(1);
                else if (pop && !push) count <= count - LW'(1);
            end
            if (vblank_i)  first_flag <= 1'b1;
            else if (pop)  first_flag <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= {s_tuser, s_tdata};
    end

    // Output register stage: everything leaves together, one cycle after its inputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rgb_o      <= BLANK_COLOR;
            hsync_o    <= 1'b0;
            vsync_o    <= 1'b0;
            de_o       <= 1'b0;
            underrun_o <= 1'b0;
            sof_err_o  <= 1'b0;
        end else begin
            rgb_o      <= pop ? head[PW-1:0] : BLANK_COLOR;
            hsync_o    <= hsync_i;
            vsync_o    <= vsync_i;
            de_o       <= active;
            underrun_o <= underrun;
            sof_err_o  <= sof_err;
        end
    end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe: 8x2 active raster, DEPTH=4, queue-based frame model
// compared every cycle, plus literal checks of the displayed pixel sequences.
module tb_vga_pixel_pipe;
    localparam int            PW     = 24;
    localparam int            DEPTH  = 4;
    localparam int            LW     = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] BLANK  = 24'hABCDEF;
    localparam int            M_SYNC = 0;
    localparam int            M_WAIT = 1;
    localparam int            M_SHOW = 2;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic          hsync_i = 1'b0, vsync_i = 1'b0, hblank_i = 1'b0, vblank_i = 1'b0;
    logic [PW-1:0] s_tdata = '0;
    logic          s_tuser = 1'b0, s_tvalid = 1'b0;
    logic          s_tready;
    logic [PW-1:0] rgb_o;
    logic          hsync_o, vsync_o, de_o, underrun_o, sof_err_o;
    logic [LW-1:0] level_o;

    int tests = 0, fails = 0;
    int hc = 0, vc = 0;
    int under_cnt = 0, sof_cnt = 0;
    logic [PW-1:0] cap[$];

    // Model state: queued {tuser,data} words, mode of the frame lock, frame-start flag.
    logic [PW:0]   q[$];
    int            mode = M_SYNC;
    bit            first = 1'b0;
    logic [PW-1:0] e_rgb = BLANK;
    logic          e_hs = 1'b0, e_vs = 1'b0, e_de = 1'b0, e_ur = 1'b0, e_se = 1'b0;
    int            e_lvl = 0;

    vga_pixel_pipe #(.PW(PW), .DEPTH(DEPTH), .BLANK_COLOR(BLANK)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .hblank_i(hblank_i), .vblank_i(vblank_i),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .underrun_o(underrun_o), .sof_err_o(sof_err_o), .level_o(level_o)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raster: 12 clocks per line (8 active), 4 lines per frame (2 active).
    task automatic drive_timing();
        hblank_i = (hc >= 8);
        vblank_i = (vc >= 2);
        hsync_i  = (hc == 9 || hc == 10);
        vsync_i  = (vc == 3);
    endtask

    initial begin
        drive_timing();
        forever begin
            @(posedge aclk);
            #1;
            hc = (hc == 11) ? 0 : hc + 1;
            if (hc == 0) vc = (vc == 3) ? 0 : vc + 1;
            drive_timing();
        end
    end

    initial begin
        bit act, room, pop;
        forever begin
            @(posedge aclk or negedge aresetn);
            if (!aresetn) begin
                q.delete();
                mode  = M_SYNC;
                first = 1'b0;
                e_rgb = BLANK;
                e_hs  = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_ur = 1'b0; e_se = 1'b0;
            end else begin
                act   = !hblank_i && !vblank_i;
                room  = q.size() < DEPTH;
                pop   = (mode == M_SHOW) && act && (q.size() != 0);
                e_ur  = (mode == M_SHOW) && act && (q.size() == 0);
                e_se  = pop && (q[0][PW] != first);
                e_rgb = pop ? q[0][PW-1:0] : BLANK;
                e_hs  = hsync_i;
                e_vs  = vsync_i;
                e_de  = act;
                if (vblank_i) first = 1'b1;
                else if (pop) first = 1'b0;
                if (pop) void'(q.pop_front());
                if (e_ur || e_se) begin
                    q.delete();
                    mode = M_SYNC;
                end else begin
                    if (mode == M_WAIT && vblank_i) mode = M_SHOW;
                    if (s_tvalid && room) begin
                        if (mode != M_SYNC) begin
                            q.push_back({s_tuser, s_tdata});
                        end else if (s_tuser) begin
                            q.push_back({s_tuser, s_tdata});
                            mode = M_WAIT;
                        end
                    end
                end
            end
            e_lvl = q.size();
        end
    end

    initial begin
        forever begin
            @(negedge aclk);
            if (underrun_o) under_cnt++;
            if (sof_err_o)  sof_cnt++;
            if (de_o && rgb_o !== BLANK) cap.push_back(rgb_o);
            check("rgb_o", rgb_o, e_rgb);
            check("hsync_o", hsync_o, e_hs);
            check("vsync_o", vsync_o, e_vs);
            check("de_o", de_o, e_de);
            check("underrun_o", underrun_o, e_ur);
            check("sof_err_o", sof_err_o, e_se);
            check("level_o", 32'(level_o), e_lvl);
            check("s_tready", s_tready, (e_lvl < DEPTH));
        end
    end

    task automatic send_word(input logic u, input logic [PW-1:0] d);
        logic rdy;
        bit   done;
        done     = 1'b0;
        s_tvalid = 1'b1;
        s_tuser  = u;
        s_tdata  = d;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge aclk);
            rdy = s_tready;
            @(posedge aclk);
            #1;
            if (rdy) done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL send_word %0h: not accepted in 300 cycles, expected acceptance", d);
        end
    endtask

    task automatic send_frame(input int n, input logic [PW-1:0] base, input logic [15:0] umask);
        for (int i = 0; i < n; i++) send_word(umask[i], base + PW'(i));
        s_tvalid = 1'b0;
    endtask

    // kind: 0 underruns>=a, 1 sof errors>=a, 2 captured>=a, 3 raster at (h=a,v=b), 4 vblank
    task automatic wait_for(input int kind, input int a, input int b, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge aclk);
            #2;
            case (kind)
                0:       ok = (under_cnt >= a);
                1:       ok = (sof_cnt >= a);
                2:       ok = (cap.size() >= a);
                3:       ok = (hc == a && vc == b);
                default: ok = (vblank_i == 1'b1);
            endcase
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_%s: condition not reached in 400 cycles, expected reached", name);
        end
    endtask

    task automatic check_cap(input logic [PW-1:0] base, input int n, input int off, input string name);
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", name, i), cap[off+i], base + PW'(i));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, rgb_o, BLANK);
        check({tag, "_hsync"}, hsync_o, 1'b0);
        check({tag, "_vsync"}, vsync_o, 1'b0);
        check({tag, "_de"}, de_o, 1'b0);
        check({tag, "_underrun"}, underrun_o, 1'b0);
        check({tag, "_sof_err"}, sof_err_o, 1'b0);
        check({tag, "_level"}, 32'(level_o), 0);
        check({tag, "_tready"}, s_tready, 1'b1);
    endtask

    initial begin
        #1 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        check_reset_outputs("por");
        @(posedge aclk);
        #3 aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Full frame with data=index, then a frame that stops after pixel 5.
        send_frame(16, 24'h00, 16'h0001);
        send_frame(6, 24'h20, 16'h0001);
        wait_for(0, 1, 0, "underrun");
        check("t12_cap_size", cap.size(), 22);
        check_cap(24'h00, 16, 0, "t1_px");
        check_cap(24'h20, 6, 16, "t2_px");
        check("t12_underruns", under_cnt, 1);
        check("t12_sof_errs", sof_cnt, 0);
        cap.delete();

        // Resync frame, then a frame with a stray start marker on pixel 3.
        send_frame(16, 24'h40, 16'h0001);
        send_frame(16, 24'h60, 16'h0009);
        wait_for(1, 1, 0, "sof_err");
        check("t3_cap_size", cap.size(), 20);
        check_cap(24'h40, 16, 0, "t3_resync_px");
        check_cap(24'h60, 4, 16, "t3_px");
        check("t3_underruns", under_cnt, 1);
        check("t3_sof_errs", sof_cnt, 1);
        cap.delete();

        // Seven non-marker words are dropped in RESYNC; the marker word is kept.
        wait_for(3, 0, 0, "frame_start");
        for (int i = 0; i < 7; i++) send_word(1'b0, 24'h80 + PW'(i));
        #1;
        check("t5_level_after_drops", 32'(level_o), 0);
        send_word(1'b1, 24'hA0);
        s_tvalid = 1'b0;
        #1;
        check("t5_level_after_sof", 32'(level_o), 1);
        fork
            send_frame(15, 24'hA1, 16'h0000);
            begin
                wait_for(4, 0, 0, "vblank");
                repeat (3) @(posedge aclk);
                #2;
                check("t4_level_full", 32'(level_o), 4);
                check("t4_tready_low", s_tready, 1'b0);
            end
        join

        // Next frame is queued behind; reset lands mid-line while the FIFO is full.
        fork
            send_frame(16, 24'hC0, 16'h0001);
            begin
                wait_for(2, 16, 0, "cap_t45");
                check("t45_cap_size", cap.size(), 16);
                check_cap(24'hA0, 16, 0, "t45_px");
                check("t45_underruns", under_cnt, 1);
                check("t45_sof_errs", sof_cnt, 1);
                cap.delete();
                wait_for(3, 10, 3, "midline");
                check("t6_level_before", 32'(level_o), 4);
                aresetn = 1'b0;
                #1;
                check_reset_outputs("t6");
                repeat (3) @(posedge aclk);
                #3 aresetn = 1'b1;
            end
        join

        send_frame(16, 24'hE0, 16'h0001);
        wait_for(2, 16, 0, "cap_t6");
        check("t6_cap_size", cap.size(), 16);
        check_cap(24'hE0, 16, 0, "t6_px");
        check("t6_underruns", under_cnt, 1);
        check("t6_sof_errs", sof_cnt, 1);

        repeat (4) @(posedge aclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
